vga_capture: RTL and testbench

//  Receive-side counterpart of the VGA conduit (HS/VS/BLANK/R/G/B). It samples the

---
 rtl/vga_capture_if.sv | 38 +++
 rtl/vga_capture.sv | 168 ++++++++++++++++
 tb/tb_vga_capture.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_capture_if.sv
// Purpose: video conduit in, captured pixels and per-frame check results out.
// Latency: n/a (signal bundle only).
// Backpressure: none; the video stream cannot be stalled.
// Ports: master = video source / result consumer, slave = vga_capture.
//   vga_hs/vga_vs (active-low syncs), vga_blank (1 = visible), vga_r/g/b colour;
//   pix_valid/pix_x/pix_y/pix_rgb captured pixel; frame_done/frame_ok/checksum/
//   err_count frame results; sync_lost watchdog strobe.
interface vga_capture_if #(
  parameter int COLOR_W = 4
);
  logic                   vga_hs;
  logic                   vga_vs;
  logic                   vga_blank;
  logic [COLOR_W-1:0]     vga_r;
  logic [COLOR_W-1:0]     vga_g;
  logic [COLOR_W-1:0]     vga_b;
  logic                   pix_valid;
  logic [10:0]            pix_x;
  logic [9:0]             pix_y;
  logic [3*COLOR_W-1:0]   pix_rgb;
  logic                   frame_done;
  logic                   frame_ok;
  logic [15:0]            checksum;
  logic [7:0]             err_count;
  logic                   sync_lost;

  modport master (
    output vga_hs, vga_vs, vga_blank, vga_r, vga_g, vga_b,
    input  pix_valid, pix_x, pix_y, pix_rgb,
    input  frame_done, frame_ok, checksum, err_count, sync_lost
  );

  modport slave (
    input  vga_hs, vga_vs, vga_blank, vga_r, vga_g, vga_b,
    output pix_valid, pix_x, pix_y, pix_rgb,
    output frame_done, frame_ok, checksum, err_count, sync_lost
  );
endinterface

// File: rtl/vga_capture.sv
// Purpose: capture looped-back VGA video, recover pixel coordinates, check line/frame timing, checksum each frame.
// Latency: pix_valid 2 cycles after the input sample; frame_done 2 cycles after VS falls at the input.
// Backpressure: none; one pixel per clk_clk is always accepted.
// Ports: clk_clk pixel clock, reset_reset_n async active-low reset,
//   vga (slave modport of vga_capture_if) carries video in and results out.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int COLOR_W  = 4
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  vga_capture_if.slave  vga
);

  localparam int LC_W     = $clog2(H_TOTAL + 1) + 1;
  localparam int LN_W     = $clog2(V_TOTAL + 1) + 1;
  localparam int WD_LIMIT = 2 * H_TOTAL * V_TOTAL;
  localparam int WD_W     = $clog2(WD_LIMIT + 1);

  localparam logic [10:0]     X_ACT   = 11'(H_ACTIVE);
  localparam logic [9:0]      Y_ACT   = 10'(V_ACTIVE);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(H_TOTAL - 1);
  localparam logic [LN_W-1:0] LN_TOT  = LN_W'(V_TOTAL);
  // Firing one count early makes sync_lost rise exactly WD_LIMIT cycles after frame_done.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

  typedef struct packed {
    logic               hs;
    logic               vs;
    logic               blank;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } vid_t;

  typedef enum logic {SEEK, FRAME} state_t;

  state_t            state, state_nxt;
  vid_t              d0;
  logic              d1_hs, d1_vs;
  logic [10:0]       x;
  logic [9:0]        y;
  logic [LN_W-1:0]   lines;
  logic [LC_W-1:0]   line_cyc;
  logic [WD_W-1:0]   wd;
  logic [15:0]       sum;
  logic              err;
  logic              hs_seen;   // an hs_fall has been seen in this frame, so line_cyc is meaningful

  logic              hs_fall, vs_fall, in_frame, wd_fire;
  logic              pix_take, pix_bad, lc_bad, x_bad, frame_ok_nxt;
  logic [10:0]       x_inc;
  logic [9:0]        y_inc, y_closed;
  logic [LN_W-1:0]   lines_inc;
  logic [LC_W-1:0]   lc_inc;

  assign hs_fall  = d1_hs & ~d0.hs;
  assign vs_fall  = d1_vs & ~d0.vs;
  assign in_frame = (state == FRAME);

  assign x_inc     = (x == '1)        ? x        : x + 11'd1;
  assign y_inc     = (y == '1)        ? y        : y + 10'd1;
  assign lines_inc = (lines == '1)    ? lines    : lines + LN_W'(1);
  assign lc_inc    = (line_cyc == '1) ? line_cyc : line_cyc + LC_W'(1);

  assign pix_take = in_frame & d0.blank & (x < X_ACT) & (y < Y_ACT);
  assign pix_bad  = in_frame & d0.blank & ~((x < X_ACT) & (y < Y_ACT));
  assign lc_bad   = hs_fall & hs_seen & (line_cyc != LC_LAST);
  assign x_bad    = (x != 11'd0) & (x != X_ACT);
  // A line with visible pixels still open at vs_fall is closed before judging the frame.
  assign y_closed = (x != 11'd0) ? y_inc : y;
  // A coincident hs_fall belongs to the new frame, so lines is not bumped here.
  assign frame_ok_nxt = ~(err | lc_bad | x_bad | pix_bad) & (y_closed == Y_ACT) & (lines == LN_TOT);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= SEEK;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wd_fire   = 1'b0;
    case (state)
      SEEK:  if (vs_fall) state_nxt = FRAME;
      FRAME: if (!vs_fall && wd == WD_LAST) begin
               state_nxt = SEEK;
               wd_fire   = 1'b1;
             end
      default: state_nxt = SEEK;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      d0             <= '0;
      d1_hs          <= 1'b0;
      d1_vs          <= 1'b0;
      x              <= '0;
      y              <= '0;
      lines          <= '0;
      line_cyc       <= '0;
      wd             <= '0;
      sum            <= '0;
      err            <= 1'b0;
      hs_seen        <= 1'b0;
      vga.pix_valid  <= 1'b0;
      vga.pix_x      <= '0;
      vga.pix_y      <= '0;
      vga.pix_rgb    <= '0;
      vga.frame_done <= 1'b0;
      vga.frame_ok   <= 1'b0;
      vga.checksum   <= '0;
      vga.err_count  <= '0;
      vga.sync_lost  <= 1'b0;
    end else begin
      d0    <= '{hs: vga.vga_hs, vs: vga.vga_vs, blank: vga.vga_blank,
                 r: vga.vga_r, g: vga.vga_g, b: vga.vga_b};
      d1_hs <= d0.hs;
      d1_vs <= d0.vs;

      vga.pix_valid  <= pix_take;
      vga.frame_done <= 1'b0;
      vga.sync_lost  <= wd_fire;
      if (pix_take) begin
        vga.pix_x   <= x;
        vga.pix_y   <= y;
        vga.pix_rgb <= {d0.r, d0.g, d0.b};
      end

      if (!in_frame || vs_fall) begin
        // Both lock-on and frame close start a fresh frame; a coincident
        // hs_fall is that frame's first line start.
        if (in_frame) begin
          vga.frame_done <= 1'b1;
          vga.frame_ok   <= frame_ok_nxt;
          vga.checksum   <= sum;
          if (!frame_ok_nxt && vga.err_count != 8'hFF)
            vga.err_count <= vga.err_count + 8'd1;
        end
        x        <= '0;
        y        <= '0;
        sum      <= '0;
        err      <= 1'b0;
        wd       <= '0;
        lines    <= (vs_fall && hs_fall) ? LN_W'(1) : '0;
        hs_seen  <= vs_fall & hs_fall;
        line_cyc <= (hs_fall || !in_frame) ? '0 : lc_inc;
      end else if (!wd_fire) begin
        wd       <= wd + WD_W'(1);
        line_cyc <= hs_fall ? '0 : lc_inc;
        if (d0.blank) x <= x_inc;
        if (pix_take) sum <= sum + 16'({d0.r, d0.g, d0.b});
        if (pix_bad || lc_bad) err <= 1'b1;
        if (hs_fall) begin
          if (x_bad) err <= 1'b1;
          y       <= y_closed;
          x       <= '0;
          lines   <= lines_inc;
          hs_seen <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
module tb_vga_capture;

  localparam int H_A       = 8;
  localparam int V_A       = 4;
  localparam int H_T       = 12;
  localparam int V_T       = 7;
  localparam int HS_COL    = 9;
  localparam int VIS_START = 2;
  localparam int LIMIT     = 2 * H_T * V_T;
  localparam int NV        = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  vga_capture_if #(.COLOR_W(4)) bus ();

  vga_capture #(
    .H_ACTIVE(H_A), .V_ACTIVE(V_A), .H_TOTAL(H_T), .V_TOTAL(V_T), .COLOR_W(4)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (reset_n),
    .vga           (bus)
  );

  typedef struct {
    bit coinc;
    int short_row;
    int long_line;
    int extra;
    int exp_ok;
    int exp_cs;
    int exp_err;
    int exp_pix;
    int exp_lx;
    int exp_ly;
  } vec_t;

  typedef struct {
    int ok;
    int cs;
    int err;
    int pix;
    int lx;
    int ly;
  } rec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pcount = 0;
  int   last_x = 0;
  int   last_y = 0;
  int   fd_cyc = 0;
  int   sl_cyc = 0;
  int   sl_total = 0;
  rec_t q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_pix_valid"},  int'(bus.pix_valid),  0);
    chk({tag, "_pix_x"},      int'(bus.pix_x),      0);
    chk({tag, "_pix_y"},      int'(bus.pix_y),      0);
    chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
    chk({tag, "_frame_ok"},   int'(bus.frame_ok),   0);
    chk({tag, "_checksum"},   int'(bus.checksum),   0);
    chk({tag, "_err_count"},  int'(bus.err_count),  0);
    chk({tag, "_sync_lost"},  int'(bus.sync_lost),  0);
  endtask

  task automatic pop_check(input string tag, input int ok, input int cs, input int err,
                           input int pix, input int lx, input int ly);
    rec_t r;
    if (q.size() == 0) begin
      chk({tag, "_frame_done_present"}, 0, 1);
    end else begin
      r = q.pop_front();
      chk({tag, "_frame_ok"},  r.ok,  ok);
      chk({tag, "_checksum"},  r.cs,  cs);
      chk({tag, "_err_count"}, r.err, err);
      chk({tag, "_pix_count"}, r.pix, pix);
      chk({tag, "_last_x"},    r.lx,  lx);
      chk({tag, "_last_y"},    r.ly,  ly);
    end
  endtask

  // One frame: VS low on lines 0-1, visible rows on lines 2..5, HS low at cycles 9-10.
  // coinc moves the VS edges onto the HS falling column.
  task automatic run_frame(input bit coinc, input int short_row, input int long_line,
                           input int extra, input bit hold_vs, input int rst_line);
    int  ncyc, row, vis_w;
    bit  vs_low, vis;
    for (int ln = 0; ln < V_T + extra; ln++) begin
      ncyc = (ln == long_line) ? H_T + 1 : H_T;
      row  = ln - VIS_START;
      for (int c = 0; c < ncyc; c++) begin
        @(posedge clk);
        #1;
        vis_w  = (row == short_row) ? H_A - 1 : H_A;
        vis    = (row >= 0) && (row < V_A) && (c < vis_w);
        vs_low = coinc ? ((ln == 0 && c >= HS_COL) || ln == 1 || (ln == 2 && c < HS_COL))
                       : (ln < 2);
        bus.vga_hs    = !(c == HS_COL || c == HS_COL + 1);
        bus.vga_vs    = hold_vs ? 1'b1 : !vs_low;
        bus.vga_blank = vis;
        bus.vga_r     = vis ? 4'(c) : 4'h0;
        bus.vga_g     = vis ? 4'(row) : 4'h0;
        bus.vga_b     = 4'h0;
        if (ln == rst_line && c == 3) reset_n = 1'b0;
        if (ln == rst_line && c == 6) reset_n = 1'b1;
        if (ln == rst_line && c == 4) begin
          @(negedge clk);
          check_idle("rst_mid");
        end
      end
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset_n) begin
      pcount = 0;
    end else begin
      if (bus.pix_valid) begin
        pcount++;
        last_x = int'(bus.pix_x);
        last_y = int'(bus.pix_y);
      end
      if (bus.frame_done) begin
        q.push_back('{int'(bus.frame_ok), int'(bus.checksum), int'(bus.err_count),
                      pcount, last_x, last_y});
        pcount = 0;
        fd_cyc = cyc;
      end
      if (bus.sync_lost) begin
        sl_total++;
        sl_cyc = cyc;
        pcount = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl [NV];
    // Full frame ramp: sum of R*256 + G*16 = 28672 + 768 = 29440.
    // Row 1 missing x=7: 29440 - (7*256 + 1*16) = 27632.
    tbl[0] = '{0, -1, -1, 0, 1, 29440, 0, 32, 7, 3};
    tbl[1] = '{0, -1, -1, 0, 1, 29440, 0, 32, 7, 3};
    tbl[2] = '{0,  1, -1, 0, 0, 27632, 1, 31, 7, 3};
    tbl[3] = '{0, -1, -1, 0, 1, 29440, 1, 32, 7, 3};
    tbl[4] = '{0, -1,  3, 0, 0, 29440, 2, 32, 7, 3};
    tbl[5] = '{0, -1, -1, 1, 0, 29440, 3, 32, 7, 3};
    tbl[6] = '{1, -1, -1, 0, 1, 29440, 3, 32, 7, 3};
    tbl[7] = '{1, -1, -1, 0, 1, 29440, 3, 32, 7, 3};

    reset_n       = 1'b0;
    bus.vga_hs    = 1'b1;
    bus.vga_vs    = 1'b1;
    bus.vga_blank = 1'b0;
    bus.vga_r     = 4'h0;
    bus.vga_g     = 4'h0;
    bus.vga_b     = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    reset_n = 1'b1;
    repeat (4) @(posedge clk);

    // Frame-level vectors; each result appears at the next frame's VS edge.
    for (int i = 0; i < NV; i++)
      run_frame(tbl[i].coinc, tbl[i].short_row, tbl[i].long_line, tbl[i].extra, 1'b0, -1);
    run_frame(1'b1, -1, -1, 0, 1'b0, -1);
    for (int i = 0; i < NV; i++)
      pop_check($sformatf("vec%0d", i), tbl[i].exp_ok, tbl[i].exp_cs, tbl[i].exp_err,
                tbl[i].exp_pix, tbl[i].exp_lx, tbl[i].exp_ly);
    chk("vec_extra_frame_done", q.size(), 0);

    // Watchdog: VS held high; sync_lost exactly LIMIT cycles after the last frame_done.
    repeat (3) run_frame(1'b0, -1, -1, 0, 1'b1, -1);
    chk("wd_sync_lost_count", sl_total, 1);
    chk("wd_sync_lost_delay", sl_cyc - fd_cyc, LIMIT);
    chk("wd_no_frame_done", q.size(), 0);
    run_frame(1'b0, -1, -1, 0, 1'b0, -1);
    chk("wd_relock_no_frame_done", q.size(), 0);
    run_frame(1'b0, -1, -1, 0, 1'b0, -1);
    pop_check("wd_relock", 1, 29440, 3, 32, 7, 3);

    // Reset on row 2: the frame is discarded and capture waits for the next VS edge.
    run_frame(1'b0, -1, -1, 0, 1'b0, 4);
    pop_check("pre_rst", 1, 29440, 3, 32, 7, 3);
    chk("rst_no_pix_before_vs", pcount, 0);
    chk("rst_no_frame_done", q.size(), 0);
    run_frame(1'b0, -1, -1, 0, 1'b0, -1);
    chk("rst_lock_no_frame_done", q.size(), 0);
    run_frame(1'b0, -1, -1, 0, 1'b0, -1);
    pop_check("post_rst", 1, 29440, 0, 32, 7, 3);
    chk("sync_lost_total", sl_total, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
